// File: rtl/cos_sample_source.sv
// cos_sample_source: streams signed Q1.5 cosine samples for the B operand of
// the A*B*C multiply chain. It is built from a phase accumulator, a
// quarter-wave ROM with symmetry folding, a burst sample counter and a
// valid/ready output handshake.
// Optional build macro SINE_SEL_EN adds a sin_sel input, latched at start.
// When sin_sel is latched high, the ROM address is shifted by a quarter turn,
// so the same folding produces sine instead of cosine.
module cos_sample_source #(
    parameter int PHASE_W = 6,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PHASE_W-1:0] step,
    input  logic [CNT_W-1:0]   n_samples,
`ifdef SINE_SEL_EN
    input  logic               sin_sel,
`endif
    output logic signed [5:0]  sample,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quarter-wave table: round(32*cos(k*pi/32)), saturated to 31, k = 0..16.
    function automatic logic [4:0] rom_t(input logic [4:0] k);
        logic [4:0] v;
        case (k)
            5'd0:    v = 5'd31;
            5'd1:    v = 5'd31;
            5'd2:    v = 5'd31;
            5'd3:    v = 5'd31;
            5'd4:    v = 5'd30;
            5'd5:    v = 5'd28;
            5'd6:    v = 5'd27;
            5'd7:    v = 5'd25;
            5'd8:    v = 5'd23;
            5'd9:    v = 5'd20;
            5'd10:   v = 5'd18;
            5'd11:   v = 5'd15;
            5'd12:   v = 5'd12;
            5'd13:   v = 5'd9;
            5'd14:   v = 5'd6;
            5'd15:   v = 5'd3;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

    // Map a 64-point wave address onto the quarter table. Magnitude never
    // exceeds 31, so the negation cannot overflow.
    function automatic logic signed [5:0] fold(input logic [5:0] p);
        logic [4:0]        idx;
        logic [4:0]        mirror;
        logic [4:0]        mag;
        logic              neg;
        logic signed [5:0] m;
        idx    = {1'b0, p[3:0]};
        mirror = 5'd16 - idx;
        case (p[5:4])
            2'd0:    begin mag = rom_t(idx);    neg = 1'b0; end
            2'd1:    begin mag = rom_t(mirror); neg = 1'b1; end
            2'd2:    begin mag = rom_t(idx);    neg = 1'b1; end
            default: begin mag = rom_t(mirror); neg = 1'b0; end
        endcase
        m = $signed({1'b0, mag});
        return neg ? -m : m;
    endfunction

    // Sine is cosine delayed by a quarter period (16 of 64 points).
    function automatic logic [5:0] wave_addr(input logic [5:0] p, input logic sel);
        return sel ? (p - 6'd16) : p;
    endfunction

    state_t              state_p0, state_nxt;
    logic [PHASE_W-1:0]  phase_p0, phase_nxt;
    logic [PHASE_W-1:0]  step_p0, step_nxt;
    logic [CNT_W-1:0]    count_p0, count_nxt;
    logic signed [5:0]   sample_nxt;
    logic                valid_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [PHASE_W-1:0]  phase_sum;
    logic                sel_start;
    logic                sel_run;

    assign phase_sum = phase_p0 + step_p0;

`ifdef SINE_SEL_EN
    logic sel_p0, sel_nxt;
    assign sel_start = sin_sel;
    assign sel_run   = sel_p0;

    // Waveform select, held for the whole burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_p0 <= 1'b0;
        else     sel_p0 <= sel_nxt;
    end
`else
    assign sel_start = 1'b0;
    assign sel_run   = 1'b0;
`endif

    // State, datapath and every output are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0     <= IDLE;
            phase_p0     <= '0;
            step_p0      <= '0;
            count_p0     <= '0;
            sample       <= 6'sd0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_p0     <= state_nxt;
            phase_p0     <= phase_nxt;
            step_p0      <= step_nxt;
            count_p0     <= count_nxt;
            sample       <= sample_nxt;
            sample_valid <= valid_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

    // Next-state and next-output logic; a transfer advances phase and
    // produces the following sample on the same edge.
    always_comb begin
        state_nxt  = state_p0;
        phase_nxt  = phase_p0;
        step_nxt   = step_p0;
        count_nxt  = count_p0;
        sample_nxt = sample;
        valid_nxt  = sample_valid;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
`ifdef SINE_SEL_EN
        sel_nxt    = sel_p0;
`endif
        case (state_p0)
            IDLE: begin
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
                if (start) begin
                    busy_nxt = 1'b1;
                    if (n_samples != '0) begin
                        step_nxt   = step;
                        count_nxt  = n_samples;
                        phase_nxt  = '0;
                        sample_nxt = fold(wave_addr(6'd0, sel_start));
                        valid_nxt  = 1'b1;
`ifdef SINE_SEL_EN
                        sel_nxt    = sin_sel;
`endif
                        state_nxt  = RUN;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (sample_valid && sample_ready) begin
                    count_nxt  = count_p0 - CNT_W'(1);
                    phase_nxt  = phase_sum;
                    sample_nxt = fold(wave_addr(phase_sum[PHASE_W-1 -: 6], sel_run));
                    if (count_p0 == CNT_W'(1)) begin
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cos_sample_source.sv
// Testbench for cos_sample_source: a scoreboard of reference samples computed
// from $cos/$sin is filled when a burst is launched and drained on each
// valid/ready transfer; scenario tasks add their own inline checks.
module tb_cos_sample_source;

    localparam int PHASE_W = 6;
    localparam int CNT_W   = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic [PHASE_W-1:0] step;
    logic [CNT_W-1:0]   n_samples;
    logic signed [5:0]  sample;
    logic               sample_valid;
    logic               sample_ready;
    logic               busy;
    logic               done;
`ifdef SINE_SEL_EN
    logic               sin_sel;
`endif

    int total;
    int bad;
    int cyc;
    int xfer_cnt;
    int done_cnt;
    int last_xfer_cyc;
    int done_cyc;
    bit valid_seen;
    logic signed [5:0] exp_q[$];
    logic signed [5:0] captured[$];

    cos_sample_source #(.PHASE_W(PHASE_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .step         (step),
        .n_samples    (n_samples),
`ifdef SINE_SEL_EN
        .sin_sel      (sin_sel),
`endif
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: round(32*cos(2*pi*p/64)) (or sin), clamped to +/-31.
    function automatic logic signed [5:0] ref_wave(input int p, input bit use_sin);
        real a;
        real v;
        int  r;
        a = 2.0 * 3.14159265358979 * p / 64.0;
        v = use_sin ? 32.0 * $sin(a) : 32.0 * $cos(a);
        r = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        if (r > 31)  r = 31;
        if (r < -31) r = -31;
        return 6'(r);
    endfunction

    task automatic monitor_step();
        logic signed [5:0] e;
        if (rst) return;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (sample_valid) valid_seen = 1'b1;
        if (sample_valid && sample_ready) begin
            xfer_cnt++;
            last_xfer_cyc = cyc;
            captured.push_back(sample);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got sample %0d with nothing expected", sample);
            end else begin
                e = exp_q.pop_front();
                if (sample !== e) begin
                    bad++;
                    $display("FAIL sb_sample[%0d]: got %0d want %0d", xfer_cnt - 1, sample, e);
                end
            end
        end
    endtask

    task automatic launch(input int stp, input int n, input bit sel);
        bit use_sin;
        use_sin = 1'b0;
`ifdef SINE_SEL_EN
        use_sin = sel;
`endif
        @(posedge clk); #1;
        xfer_cnt   = 0;
        done_cnt   = 0;
        valid_seen = 1'b0;
        captured.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(ref_wave((k * stp) % 64, use_sin & sel));
        step      = PHASE_W'(stp);
        n_samples = CNT_W'(n);
`ifdef SINE_SEL_EN
        sin_sel   = sel;
`endif
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start        = 1'($urandom);
            step         = PHASE_W'($urandom);
            n_samples    = CNT_W'($urandom);
            sample_ready = 1'($urandom);
            @(negedge clk);
            total++;
            if ({sample, sample_valid, busy, done} !== 9'b0) begin
                bad++;
                $display("FAIL reset_hold: got sample=%b valid=%b busy=%b done=%b want all 0",
                         sample, sample_valid, busy, done);
            end
        end
        @(posedge clk); #1;
        start        = 1'b0;
        sample_ready = 1'b1;
        rst          = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({sample, sample_valid, busy, done} !== 9'b0) begin
                bad++;
                $display("FAIL reset_idle: got sample=%b valid=%b busy=%b done=%b want all 0",
                         sample, sample_valid, busy, done);
            end
        end
    endtask

    task automatic test_full_period();
        bit ok;
        sample_ready = 1'b1;
        launch(1, 64, 1'b0);
        @(negedge clk);
        total++;
        if (sample_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL full_latency: got valid=%b busy=%b want 1 1", sample_valid, busy);
        end
        wait_done(200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL full_done_timeout: got no done want done within 200 cycles");
        end
        total++;
        if (xfer_cnt !== 64) begin
            bad++;
            $display("FAIL full_count: got %0d transfers want 64", xfer_cnt);
        end
        total++;
        if (done_cyc - last_xfer_cyc !== 1) begin
            bad++;
            $display("FAIL full_done_timing: got done %0d cycles after last transfer want 1",
                     done_cyc - last_xfer_cyc);
        end
        total++;
        if (captured[0] !== 6'sd31 || captured[4] !== 6'sd30 || captured[16] !== 6'sd0) begin
            bad++;
            $display("FAIL full_points_a: got %0d %0d %0d want 31 30 0",
                     captured[0], captured[4], captured[16]);
        end
        total++;
        if (captured[32] !== 6'b100001 || captured[48] !== 6'sd0 || captured[63] !== 6'sd31) begin
            bad++;
            $display("FAIL full_points_b: got %b %0d %0d want 100001 0 31",
                     captured[32], captured[48], captured[63]);
        end
    endtask

    task automatic test_coarse_wrap();
        bit ok;
        logic signed [5:0] want[6];
        want = '{6'sd31, 6'sd0, -6'sd31, 6'sd0, 6'sd31, 6'sd0};
        sample_ready = 1'b1;
        launch(16, 6, 1'b0);
        wait_done(40, ok);
        total++;
        if (!ok || xfer_cnt !== 6) begin
            bad++;
            $display("FAIL coarse_done: got done=%0d transfers=%0d want 1 6", ok, xfer_cnt);
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (captured[k] !== want[k]) begin
                bad++;
                $display("FAIL coarse_seq[%0d]: got %0d want %0d", k, captured[k], want[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        sample_ready = 1'b1;
        launch(1, 8, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (xfer_cnt >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_reach2: got %0d transfers want 2 within 20 cycles", xfer_cnt);
        end
        #1;
        sample_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (sample_valid !== 1'b1 || sample !== 6'sd31) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b sample=%0d want 1 31", i, sample_valid, sample);
            end
        end
        @(posedge clk); #1;
        sample_ready = 1'b1;
        wait_done(40, ok);
        total++;
        if (!ok || xfer_cnt !== 8 || done_cnt !== 1) begin
            bad++;
            $display("FAIL bp_done: got done=%0d transfers=%0d pulses=%0d want 1 8 1", ok, xfer_cnt, done_cnt);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        bit ok;
        sample_ready = 1'b1;
        launch(3, 0, 1'b0);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || sample_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_done: got done=%b valid=%b busy=%b want 1 0 1", done, sample_valid, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_after: got done=%b busy=%b want 0 0", done, busy);
        end
        #1;
        total++;
        if (valid_seen !== 1'b0 || xfer_cnt !== 0) begin
            bad++;
            $display("FAIL zero_valid: got valid_seen=%0d transfers=%0d want 0 0", valid_seen, xfer_cnt);
        end
        launch(4, 10, 1'b0);
        @(posedge clk); #1;
        step      = PHASE_W'(1);
        n_samples = CNT_W'(3);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        wait_done(40, ok);
        total++;
        if (!ok || xfer_cnt !== 10 || done_cnt !== 1 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL ignored_start: got done=%0d transfers=%0d pulses=%0d left=%0d want 1 10 1 0",
                     ok, xfer_cnt, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        sample_ready = 1'b1;
        launch(1, 64, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (xfer_cnt >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL midrst_reach5: got %0d transfers want 5 within 20 cycles", xfer_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({sample, sample_valid, busy, done} !== 9'b0) begin
            bad++;
            $display("FAIL midrst_async: got sample=%b valid=%b busy=%b done=%b want all 0",
                     sample, sample_valid, busy, done);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++;
        if (done_cnt !== 0) begin
            bad++;
            $display("FAIL midrst_nodone: got %0d done pulses want 0", done_cnt);
        end
        launch(1, 4, 1'b0);
        wait_done(30, ok);
        total++;
        if (!ok || xfer_cnt !== 4 || captured[0] !== 6'sd31) begin
            bad++;
            $display("FAIL midrst_restart: got done=%0d transfers=%0d first=%0d want 1 4 31",
                     ok, xfer_cnt, captured[0]);
        end
    endtask

`ifdef SINE_SEL_EN
    task automatic test_sine();
        bit ok;
        sample_ready = 1'b1;
        launch(16, 4, 1'b1);
        wait_done(30, ok);
        total++;
        if (!ok || xfer_cnt !== 4 || captured[0] !== 6'sd0 || captured[1] !== 6'sd31
            || captured[3] !== -6'sd31) begin
            bad++;
            $display("FAIL sine: got done=%0d n=%0d %0d %0d %0d want 1 4 0 31 -31",
                     ok, xfer_cnt, captured[0], captured[1], captured[3]);
        end
        sin_sel = 1'b0;
    endtask
`endif

    initial begin
        total         = 0;
        bad           = 0;
        cyc           = 0;
        xfer_cnt      = 0;
        done_cnt      = 0;
        last_xfer_cyc = 0;
        done_cyc      = 0;
        valid_seen    = 1'b0;
        rst           = 1'b1;
        start         = 1'b0;
        step          = '0;
        n_samples     = '0;
        sample_ready  = 1'b1;
`ifdef SINE_SEL_EN
        sin_sel       = 1'b0;
`endif
        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none
        test_reset();
        test_full_period();
        test_coarse_wrap();
        test_backpressure();
        test_zero_and_ignored_start();
        test_reset_mid_run();
`ifdef SINE_SEL_EN
        test_sine();
`endif
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending samples want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
